// File: rtl/gf64_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gf64_pkg
//  Description : Shared widths, default reduction polynomial and sequential
//                FSM state encoding for the GF(2^64) datapath blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package gf64_pkg;

    localparam int          GF64_W            = 64;
    localparam int          GF64_PW           = 128;
    localparam logic [63:0] GF64_POLY_DEFAULT = 64'h1B;

    // Common three-phase handshake FSM used by GF64 sequential blocks
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gf64_state_e;

endpackage : gf64_pkg
`default_nettype wire

// File: rtl/gf64_reduce_step.sv
`default_nettype none
// ============================================================================
//  Module      : gf64_reduce_step
//  Description : Combinational slice of the polynomial divider. Eliminates
//                STEP dividend bits, MSB first, starting at bit i_base, and
//                returns the updated working value plus the quotient bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module gf64_reduce_step
    import gf64_pkg::*;
#(
    parameter logic [63:0] POLY = GF64_POLY_DEFAULT,
    parameter int          STEP = 4
) (
    input  logic [GF64_PW-1:0] i_w,
    input  logic [6:0]         i_base,
    output logic [GF64_PW-1:0] o_w,
    output logic [STEP-1:0]    o_q
);

    // Full divisor x^64 + POLY, aligned at bit 0 and shifted under each
    // eliminated bit.
    localparam logic [GF64_PW-1:0] c_POLY_FULL = {63'd0, 1'b1, POLY};

    logic [GF64_PW-1:0] w_acc;
    logic [6:0]         w_pos;

    // Chain of STEP conditional XOR stages; each stage sees the previous one's result
    always_comb begin
        w_acc = i_w;
        w_pos = '0;
        o_q   = '0;
        for (int j = 0; j < STEP; j++) begin
            w_pos           = i_base - 7'(j);
            o_q[STEP-1-j]   = w_acc[w_pos];
            if (w_acc[w_pos]) begin
                // w_pos is in 64..127, so the 7-bit subtract gives the shift 0..63
                w_acc = w_acc ^ (c_POLY_FULL << (w_pos - 7'd64));
            end
        end
        o_w = w_acc;
    end

endmodule : gf64_reduce_step
`default_nettype wire

// File: rtl/gf64_reduce.sv
`default_nettype none
// ============================================================================
//  Module      : gf64_reduce
//  Description : Sequential GF(2)[x] divider. Reduces a 128-bit carryless
//                product modulo x^64 + POLY, STEP bits per cycle, returning
//                remainder and quotient behind valid/ready handshakes.
//                Latency is data-independent (64/STEP RUN cycles always).
//  Revision    : 1.0 - initial release
// ============================================================================
module gf64_reduce
    import gf64_pkg::*;
#(
    parameter logic [63:0] POLY = GF64_POLY_DEFAULT,
    parameter int          STEP = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [GF64_PW-1:0]  in_product,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [GF64_W-1:0]   out_rem,
    output logic [GF64_W-1:0]   out_quot
);

    localparam int         c_NUM_STEPS = 64 / STEP;
    localparam logic [5:0] c_LAST_CNT  = 6'(c_NUM_STEPS - 1);

    // Only power-of-two STEP values up to 32 divide the 64 quotient bits evenly
    generate
        if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8 ||
              STEP == 16 || STEP == 32)) begin : g_bad_step
            $error("gf64_reduce: STEP must be one of 1,2,4,8,16,32");
        end
    endgenerate

    gf64_state_e        r_state;
    gf64_state_e        w_state_nxt;
    logic [GF64_PW-1:0] r_w;
    logic [GF64_W-1:0]  r_q;
    logic [5:0]         r_cnt;
    logic [GF64_W-1:0]  r_rem;
    logic [GF64_W-1:0]  r_quot;

    logic [6:0]         w_base;
    logic [GF64_PW-1:0] w_w_nxt;
    logic [STEP-1:0]    w_q_bits;
    logic [GF64_W-1:0]  w_q_nxt;
    logic               w_last;

    // Highest bit still to be eliminated this cycle
    assign w_base  = 7'd127 - 7'(int'(r_cnt) * STEP);
    assign w_last  = (r_cnt == c_LAST_CNT);
    // Quotient bits emerge MSB first, so they shift in from the bottom
    assign w_q_nxt = {r_q[GF64_W-1-STEP:0], w_q_bits};

    gf64_reduce_step #(
        .POLY (POLY),
        .STEP (STEP)
    ) u_step (
        .i_w    (r_w),
        .i_base (w_base),
        .o_w    (w_w_nxt),
        .o_q    (w_q_bits)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // Working registers, step counter and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w    <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quot <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_w   <= in_product;
                        r_q   <= '0;
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_w   <= w_w_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + 6'd1;
                    if (w_last) begin
                        r_rem  <= w_w_nxt[GF64_W-1:0];
                        r_quot <= w_q_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_rem   = r_rem;
    assign out_quot  = r_quot;

endmodule : gf64_reduce
`default_nettype wire

// File: tb/tb_gf64_reduce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gf64_reduce
//  Description : Directed self-checking bench for gf64_reduce at STEP=4 with
//                the default polynomial x^64+x^4+x^3+x+1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gf64_reduce;

    localparam logic [63:0] c_POLY = 64'h1B;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_product;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_rem;
    logic [63:0]  out_quot;

    int checks   = 0;
    int failures = 0;

    gf64_reduce #(
        .POLY (c_POLY),
        .STEP (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_product (in_product),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rem    (out_rem),
        .out_quot   (out_quot)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Carryless product quot * (x^64 + POLY)
    function automatic logic [127:0] clmul_div(input logic [63:0] q);
        logic [127:0] acc;
        logic [127:0] d;
        acc = '0;
        d   = {63'd0, 1'b1, c_POLY};
        for (int i = 0; i < 64; i++) begin
            if (q[i]) acc = acc ^ (d << i);
        end
        return acc;
    endfunction

    // Present one operand, return cycles from accept edge to out_valid
    task automatic run_op(input logic [127:0] p, input bit pulse, output int lat);
        @(negedge clk);
        in_valid   = 1'b1;
        in_product = p;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_product = '0;
        lat = 0;
        while (lat < 100 && out_valid !== 1'b1) begin
            @(posedge clk);
            #1;
            lat++;
            if (pulse && lat == 3) begin
                in_valid   = 1'b1;
                in_product = {64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0};
            end else begin
                in_valid   = 1'b0;
            end
        end
    endtask

    // Handshake edge with out_ready high: back to IDLE on the next cycle
    task automatic finish_op(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_in_ready_after"},  {127'd0, in_ready},  128'd1);
        check({tag, "_out_valid_after"}, {127'd0, out_valid}, 128'd0);
    endtask

    task automatic directed(input string tag, input logic [127:0] p,
                            input logic [63:0] exp_rem, input logic [63:0] exp_quot);
        int lat;
        run_op(p, 1'b0, lat);
        check({tag, "_latency"}, 128'(lat), 128'd16);
        check({tag, "_rem"},  {64'd0, out_rem},  {64'd0, exp_rem});
        check({tag, "_quot"}, {64'd0, out_quot}, {64'd0, exp_quot});
        finish_op(tag);
    endtask

    initial begin
        int lat;
        logic [127:0] rp;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_product = '0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready",  {127'd0, in_ready},  128'd1);
        check("reset_out_valid", {127'd0, out_valid}, 128'd0);
        check("reset_rem",       {64'd0, out_rem},    128'd0);
        check("reset_quot",      {64'd0, out_quot},   128'd0);
        @(negedge clk);
        rst = 1'b0;

        // Hand-reduced vectors (x^64 = x^4+x^3+x+1)
        directed("x64",       128'h1 << 64,                        64'h1B,                 64'h1);
        directed("x65",       128'h2 << 64,                        64'h36,                 64'h2);
        directed("x64_plus_p",(128'h1 << 64) | 128'h1B,            64'h0,                  64'h1);
        directed("x65_x64",   128'h3 << 64,                        64'h2D,                 64'h3);
        directed("low_only",  128'hDEADBEEF_CAFEF00D,              64'hDEADBEEF_CAFEF00D,  64'h0);
        directed("x127",      128'h1 << 127,                       64'h8000_0000_0000_00AF, 64'h8000_0000_0000_000D);

        // Backpressure with in_valid pulsed during RUN and DONE
        out_ready = 1'b0;
        run_op(128'h3 << 64, 1'b1, lat);
        check("bp_latency", 128'(lat), 128'd16);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid   = (i % 3 == 0);
            in_product = 128'h1 << 127;
            @(posedge clk);
            #1;
            check("bp_out_valid", {127'd0, out_valid}, 128'd1);
            check("bp_in_ready",  {127'd0, in_ready},  128'd0);
            check("bp_rem",       {64'd0, out_rem},    128'h2D);
            check("bp_quot",      {64'd0, out_quot},   128'h3);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        finish_op("bp");

        // Reset during RUN cycle 5 discards the operation
        @(negedge clk);
        in_valid   = 1'b1;
        in_product = 128'h1 << 127;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrun_rst_in_ready",  {127'd0, in_ready},  128'd1);
        check("midrun_rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("midrun_rst_rem",       {64'd0, out_rem},    128'd0);
        check("midrun_rst_quot",      {64'd0, out_quot},   128'd0);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midrun_no_spurious_valid", {127'd0, out_valid}, 128'd0);
        directed("after_rst_x65", 128'h2 << 64, 64'h36, 64'h2);

        // Random operands: quotient and remainder must reconstruct the dividend
        for (int n = 0; n < 6; n++) begin
            rp = {$urandom, $urandom, $urandom, $urandom};
            run_op(rp, 1'b0, lat);
            check("rand_latency",   128'(lat), 128'd16);
            check("rand_invariant", clmul_div(out_quot) ^ {64'd0, out_rem}, rp);
            finish_op("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_gf64_reduce
`default_nettype wire

// File: doc/gf64_reduce.md
# gf64_reduce

Sequential GF(2)[x] polynomial divider that takes the 128-bit carryless product from the GF(2^64) multiplier and reduces it modulo a fixed degree-64 field polynomial. It returns the 64-bit field element (remainder) and the 64-bit quotient. It is the back end of the multiply path: multiplier output feeds this block, and its remainder is the field-multiply result for downstream logic. Valid/ready handshakes sit on both sides, and the block processes a configurable number of dividend bits per cycle.

## Interface
- `POLY`, default `64'h000000000000001B`: low 64 coefficients of the reduction polynomial. The x^64 term is implicit, so the default is x^64+x^4+x^3+x+1.
- `STEP`, default 4: dividend bits eliminated per cycle. Legal values are 1, 2, 4, 8, 16 and 32. Any other value must fail elaboration.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `in_product` is valid.
- `in_ready` output 1: block can accept an operand.
- `in_product` input 128: dividend. Bit i is the coefficient of x^i.
- `out_valid` output 1: result registers hold a completed result.
- `out_ready` input 1: consumer accepts the result.
- `out_rem` output 64: remainder, i.e. `in_product` mod (x^64 + `POLY`).
- `out_quot` output 64: quotient.

## Operation
- FSM with three states:
  - IDLE: `in_ready`=1. Leaves IDLE on `in_valid & in_ready`.
  - RUN: `in_ready`=0, `out_valid`=0.
  - DONE: `out_valid`=1. Leaves DONE on `out_valid & out_ready`.
- Accept (IDLE): load working register W[127:0] ← `in_product`, clear Q, clear step counter C, go to RUN.
- Each RUN cycle processes bit positions i = 127−C·STEP down to 128−(C+1)·STEP, strictly MSB first and sequentially within the cycle:
  - q = W[i];
  - if q, W ^= ({1'b1, POLY} << (i−64));
  - Q[i−64] = q.
- After 64/STEP RUN cycles, W[127:64] must be zero. The block then registers `out_rem` ← W[63:0] and `out_quot` ← Q, and goes to DONE.
- Invariant: `out_quot` · (x^64+`POLY`) XOR `out_rem` == `in_product` (carryless arithmetic).
- Input already below degree 64 (`in_product[127:64]`=0): still takes the full 64/STEP RUN cycles, with `out_quot`=0 and `out_rem`=`in_product[63:0]`. There is no early exit, so latency is data-independent (constant-time requirement).
- `in_valid` while not in IDLE: ignored, and the operand is not captured.
- Backpressure: in DONE with `out_ready`=0, `out_rem` and `out_quot` hold stable. `out_valid` stays 1 until the handshake.
- `rst`=1 on any edge, including mid-RUN or in DONE:
  - state goes to IDLE, `in_ready`=1 from the following cycle;
  - `out_valid`=0, `out_rem`=0, `out_quot`=0;
  - W, Q and C are cleared;
  - any in-flight operation is discarded with no output.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_rem`=0, `out_quot`=0.
- Accept at edge k. RUN occupies edges k+1 … k+64/STEP. `out_valid` rises after edge k+64/STEP, which is 16 cycles at STEP=4.
- DONE-to-IDLE happens on the output handshake edge. `in_ready`=1 in the next cycle; there is no same-cycle turnaround.
- Peak throughput, with `out_ready` held high: one result per 64/STEP+2 cycles.
- All outputs are registered. No combinational path from `in_valid` or `out_ready` to any output.
- Critical path: STEP chained conditional XOR stages across 128 bits. STEP=16 is the largest value intended for timing closure.

## Structure
- Shared package `gf64_pkg`:
  - `GF64_W`=64 and `GF64_PW`=128;
  - `GF64_POLY_DEFAULT`=`64'h1B`;
  - the FSM state enum {IDLE, RUN, DONE}, also used by future GF64 sequential blocks.
- One combinational sub-module, `gf64_reduce_step`:
  - inputs: W and the base bit position;
  - outputs: next W and STEP quotient bits;
  - instantiated once; the top holds the FSM, counter and registers.

## Test plan
- Single operations, `out_ready` held high, STEP=4, default `POLY`:
  - `in_product`=`128'h1`<<64 → `out_rem`=`64'h1B`, `out_quot`=`64'h1`; `out_valid` exactly 16 cycles after the accept edge.
  - `in_product`=`128'h2`<<64 → `out_rem`=`64'h36`, `out_quot`=`64'h2`.
  - `in_product`=(`128'h1`<<64) | `64'h1B` → `out_rem`=0, `out_quot`=1.
  - `in_product`=`64'hDEADBEEF_CAFEF00D` (upper half 0) → `out_rem`=`64'hDEADBEEF_CAFEF00D`, `out_quot`=0; same 16-cycle latency.
- Backpressure:
  - hold `out_ready`=0 for 10 cycles in DONE → outputs stable and `out_valid` held throughout;
  - `in_valid` pulsed during RUN/DONE → ignored;
  - handshake → `in_ready`=1 on the next cycle.
- Reset mid-RUN: assert `rst` at RUN cycle 5 → next cycle `in_ready`=1, `out_valid`=0, `out_rem`=`out_quot`=0. A fresh operand afterwards yields a correct result.
- Random: 10k random a, b fed through the GF(2^64) multiplier into this block, at every legal STEP with random `out_ready` →
  - the invariant holds;
  - `out_rem` matches the software GF(2^64) model;
  - `out_rem`[63:0] < x^64 trivially, and quotient degree ≤ 63.
